if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined CPU; initiator side of the instruction-ROM interface.
- Holds the PC and drives the byte address to the combinational instruction ROM (ROM indexes by addr[7:2], 64 words).
- Captures the returned instruction into the IF/ID pipeline register.
- Handles sequential fetch, branch/jump redirect, stall (hold) and flush (bubble injection) from the hazard unit.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/if_fetch_unit_if.sv | 12 +
 rtl/if_pc_gen.sv | 41 ++++
 rtl/if_fetch_unit.sv | 99 +++++++++
 tb/tb_if_fetch_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage, the decode stage and the
// hazard unit: instruction width, NOP encoding, PC step and reset vector.
package cpu_pkg;

  localparam int unsigned  INST_W           = 32;
  localparam logic [31:0]  NOP_INST         = 32'h0000_0000;
  localparam logic [31:0]  PC_INCR          = 32'd4;
  localparam logic [31:0]  RESET_PC_DEFAULT = 32'h0000_0000;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
    logic [31:0]       pc4;
    logic              valid;
  } ifid_t;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-ROM bus: the fetch stage drives the byte address, the ROM
// answers combinationally in the same cycle.
interface if_fetch_unit_if;
  import cpu_pkg::*;

  logic [31:0]       rom_addr;
  logic [INST_W-1:0] rom_inst;

  modport master (output rom_addr, input rom_inst);
  modport slave  (input rom_addr, output rom_inst);

endinterface

// File: rtl/if_pc_gen.sv
// Program counter: register, next-PC select (redirect > hold > +4) and the
// +4 adder shared with the IF/ID register.
module if_pc_gen
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  logic [31:0] next_pc;

  // Sequential address wraps modulo 2^32
  assign pc4 = pc + PC_INCR;

  // A redirect wins over a stall so a taken branch is never lost
  always_comb begin
    next_pc = pc4;
    if (br_taken) begin
      next_pc = word_align(br_target);
    end else if (stall) begin
      next_pc = pc;
    end
  end

  // PC register; reset discards any pending redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the ROM address from the PC and captures
// the returned word into the IF/ID register (flush > stall > load).
// Optional build macro IF_BOUND_CHECK_EN: fetches at or beyond the ROM end
// load a bubble and set the sticky fetch_err flag.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned ROM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  if_fetch_unit_if.master   rom,
  output logic [INST_W-1:0] id_inst,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc4,
  output logic              id_valid,
  output logic              fetch_err
);

  logic [31:0]       pc_p0;
  logic [31:0]       pc4_p0;
  logic [INST_W-1:0] load_inst_p0;
  logic              load_valid_p0;
  ifid_t             ifid_p1;

  if_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc        (pc_p0),
    .pc4       (pc4_p0)
  );

  assign rom.rom_addr = pc_p0;

`ifdef IF_BOUND_CHECK_EN
  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS * 4);

  logic out_of_range_p0;
  logic fetch_err_q;

  assign out_of_range_p0 = (pc_p0 >= ROM_LIMIT);

  // Out-of-range fetches become bubbles instead of aliased ROM words
  always_comb begin
    load_inst_p0  = rom.rom_inst;
    load_valid_p0 = 1'b1;
    if (out_of_range_p0) begin
      load_inst_p0  = NOP_INST;
      load_valid_p0 = 1'b0;
    end
  end

  // Sticky error: set on any loading edge that fetched out of range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err_q <= 1'b0;
    end else if (!flush && !stall && out_of_range_p0) begin
      fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  // Keeps the depth parameter referenced when the bound check is compiled out
  logic [31:0] unused_rom_words;
  assign unused_rom_words = 32'(ROM_WORDS);

  assign load_inst_p0  = rom.rom_inst;
  assign load_valid_p0 = 1'b1;
  assign fetch_err     = 1'b0;
`endif

  // IF/ID boundary: bubble on flush, hold on stall, otherwise capture fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_p1 <= '{inst: NOP_INST, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
    end else if (flush) begin
      ifid_p1 <= '{inst: NOP_INST, pc: pc_p0, pc4: pc4_p0, valid: 1'b0};
    end else if (!stall) begin
      ifid_p1 <= '{inst: load_inst_p0, pc: pc_p0, pc4: pc4_p0, valid: load_valid_p0};
    end
  end

  assign id_inst  = ifid_p1.inst;
  assign id_pc    = ifid_p1.pc;
  assign id_pc4   = ifid_p1.pc4;
  assign id_valid = ifid_p1.valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed steps followed by random control traffic,
// all checked against a reference model of the fetch rules.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  localparam int ROM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, br_taken;
  logic [31:0] br_target;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic        id_valid, fetch_err;

  logic [31:0] w_inst, w_pc, w_pc4;
  logic        w_valid, w_err;

  logic [31:0] rom_mem [ROM_WORDS];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_pc, m_inst, m_idpc, m_idpc4;
  logic        m_valid, m_err;

  always #5 clk = ~clk;

  if_fetch_unit_if rom_bus ();
  if_fetch_unit_if rom_bus_w ();

  assign rom_bus.rom_inst   = rom_mem[rom_bus.rom_addr[7:2]];
  assign rom_bus_w.rom_inst = rom_mem[rom_bus_w.rom_addr[7:2]];

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .ROM_WORDS(ROM_WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .br_taken  (br_taken),
    .br_target (br_target),
    .rom       (rom_bus),
    .id_inst   (id_inst),
    .id_pc     (id_pc),
    .id_pc4    (id_pc4),
    .id_valid  (id_valid),
    .fetch_err (fetch_err)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .ROM_WORDS(ROM_WORDS)) dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (1'b0),
    .flush     (1'b0),
    .br_taken  (1'b0),
    .br_target (32'h0),
    .rom       (rom_bus_w),
    .id_inst   (w_inst),
    .id_pc     (w_pc),
    .id_pc4    (w_pc4),
    .id_valid  (w_valid),
    .fetch_err (w_err)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_idpc = 32'h0; m_idpc4 = 32'h0;
    m_valid = 1'b0; m_err = 1'b0;
  endtask

  // One clock edge of the fetch rules, applied to the pre-edge state
  task automatic model_edge(input logic st, input logic fl, input logic br, input logic [31:0] tgt);
    logic [31:0] cur;
    cur = m_pc;
    if (fl) begin
      m_inst = 32'h0; m_valid = 1'b0; m_idpc = cur; m_idpc4 = cur + 32'd4;
    end else if (!st) begin
      m_idpc  = cur;
      m_idpc4 = cur + 32'd4;
`ifdef IF_BOUND_CHECK_EN
      if (cur >= 32'(ROM_WORDS * 4)) begin
        m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b1;
      end else begin
        m_inst = rom_mem[cur[7:2]]; m_valid = 1'b1;
      end
`else
      m_inst = rom_mem[cur[7:2]]; m_valid = 1'b1;
`endif
    end
    if (br)       m_pc = {tgt[31:2], 2'b00};
    else if (!st) m_pc = cur + 32'd4;
  endtask

  task automatic check_all(input string tag);
    check32({tag, "_rom_addr"}, rom_bus.rom_addr, m_pc);
    check32({tag, "_id_inst"},  id_inst,  m_inst);
    check32({tag, "_id_pc"},    id_pc,    m_idpc);
    check32({tag, "_id_pc4"},   id_pc4,   m_idpc4);
    check32({tag, "_id_valid"}, 32'(id_valid),  32'(m_valid));
    check32({tag, "_fetch_err"}, 32'(fetch_err), 32'(m_err));
  endtask

  task automatic cycle(input string tag, input logic st, input logic fl,
                       input logic br, input logic [31:0] tgt);
    stall = st; flush = fl; br_taken = br; br_target = tgt;
    @(posedge clk);
    model_edge(st, fl, br, tgt);
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] seq_w [4];
    seq_w[0] = 32'h00100443; seq_w[1] = 32'h00201025;
    seq_w[2] = 32'h041018E1; seq_w[3] = 32'h04202021;
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
    for (int i = 0; i < 4; i++) rom_mem[i] = seq_w[i];

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // sequential fetch of words 0..3
    for (int k = 0; k < 4; k++) begin
      cycle("seq", 1'b0, 1'b0, 1'b0, 32'h0);
      check32("seq_word", id_inst, seq_w[k]);
      check32("seq_pc", id_pc, 32'(k * 4));
      check32("seq_pc4", id_pc4, 32'(k * 4 + 4));
      if (k == 0) begin
        check32("wrap_pc", rom_bus_w.rom_addr, 32'h0);
        check32("wrap_id_pc", w_pc, 32'hFFFF_FFFC);
        check32("wrap_id_pc4", w_pc4, 32'h0);
        check32("wrap_id_inst", w_inst, rom_mem[63]);
        check32("wrap_valid", 32'(w_valid), 32'd1);
      end
    end

    // go back to word 1, then stall two cycles with pc=8
    cycle("redir4", 1'b0, 1'b1, 1'b1, 32'h4);
    cycle("load1", 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      cycle("stall", 1'b1, 1'b0, 1'b0, 32'h0);
      check32("stall_addr", rom_bus.rom_addr, 32'h8);
      check32("stall_hold", id_inst, seq_w[1]);
    end
    cycle("after_stall", 1'b0, 1'b0, 1'b0, 32'h0);
    check32("after_stall_word", id_inst, seq_w[2]);

    // taken branch with flush to an unaligned target
    cycle("br_flush", 1'b0, 1'b1, 1'b1, 32'h0000_0003);
    check32("br_flush_pc", rom_bus.rom_addr, 32'h0);
    check32("br_flush_valid", 32'(id_valid), 32'd0);
    cycle("br_target_load", 1'b0, 1'b0, 1'b0, 32'h0);
    check32("br_target_word", id_inst, seq_w[0]);

    // stall + flush + branch together, then stall alone
    cycle("all3", 1'b1, 1'b1, 1'b1, 32'h10);
    check32("all3_pc", rom_bus.rom_addr, 32'h10);
    check32("all3_bubble", id_inst, 32'h0);
    cycle("stall_only", 1'b1, 1'b0, 1'b0, 32'h0);
    check32("stall_only_pc", rom_bus.rom_addr, 32'h10);

    // asynchronous reset in the middle of a stalled redirect
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h40;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    cycle("post_rst", 1'b0, 1'b0, 1'b0, 32'h0);
    check32("post_rst_word", id_inst, seq_w[0]);

    // fetch beyond the ROM and come back
    cycle("oob_br", 1'b0, 1'b1, 1'b1, 32'h100);
    cycle("oob_load", 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef IF_BOUND_CHECK_EN
    check32("oob_valid", 32'(id_valid), 32'd0);
    check32("oob_err", 32'(fetch_err), 32'd1);
`else
    check32("oob_alias", id_inst, seq_w[0]);
    check32("oob_err", 32'(fetch_err), 32'd0);
`endif
    cycle("back_br", 1'b0, 1'b1, 1'b1, 32'h0);
    cycle("back_load", 1'b0, 1'b0, 1'b0, 32'h0);

    // random control traffic
    for (int n = 0; n < 400; n++) begin
      logic        st, fl, br;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 5) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 511));
      cycle("rand", st, fl, br, tgt);
    end

    // reset clears the sticky flag
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("final_rst");
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
